// File: rtl/ble_auth_rx.sv
// BLE command front end: 8N1 UART receiver feeding the power authorisation FSM.
// 'G' powers the Segway up; 'S' powers it down once the rider has stepped off.
module ble_auth_rx #(
  parameter int         BAUD_DIV = 2604,
  parameter logic [7:0] CMD_GO   = 8'h47,
  parameter logic [7:0] CMD_STOP = 8'h53
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       pwr_up,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       dbg_rx_busy,
  output logic [1:0] dbg_auth_state
);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [1:0] {AUTH_OFF = 2'd0, AUTH_PWR1 = 2'd1, AUTH_PWR2 = 2'd2} auth_state_t;

  // The counter samples when it reads zero, so loads are one less than the wanted cycle spacing.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_LOAD = 12'(BAUD_DIV - 1);

  rx_state_t   rx_state, rx_next;
  auth_state_t auth_state, auth_next;
  logic        rx_meta, rx_s, rx_s_q;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  data_sr;
  logic        start_det, sample_tick, last_sample, data_bit, byte_ok, byte_bad;
  logic        consume_go, consume_stop;

  // Handshake: rx_rdy is valid for exactly one cycle; the auth FSM always takes the byte in that cycle.
  assign start_det   = (rx_state == RX_IDLE) && rx_s_q && !rx_s;
  assign sample_tick = (rx_state == RX_RECV) && (baud_cnt == 12'd0);
  assign last_sample = sample_tick && (bit_cnt == 4'd9);
  assign data_bit    = sample_tick && (bit_cnt != 4'd0) && (bit_cnt != 4'd9);
  assign byte_ok     = last_sample && rx_s;
  assign byte_bad    = last_sample && !rx_s;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (start_det) rx_next = RX_RECV;
      RX_RECV: if (last_sample) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= RX;
      rx_s      <= rx_meta;
      rx_s_q    <= rx_s;
      rx_state  <= rx_next;
      frame_err <= byte_bad;
      if (start_det) begin
        baud_cnt <= HALF_LOAD;
        bit_cnt  <= '0;
      end else if (sample_tick) begin
        baud_cnt <= FULL_LOAD;
        bit_cnt  <= bit_cnt + 4'd1;
      end else if (rx_state == RX_RECV) begin
        baud_cnt <= baud_cnt - 12'd1;
      end
      // Only data bits enter the LSB-first shifter; start is ignored and stop is checked live.
      if (data_bit) data_sr <= {rx_s, data_sr[7:1]};
      if (byte_ok) rx_data <= data_sr;
      if (byte_ok) rx_rdy <= 1'b1;
      else if (rx_rdy || start_det) rx_rdy <= 1'b0;
    end
  end

  assign consume_go   = rx_rdy && (rx_data == CMD_GO);
  assign consume_stop = rx_rdy && (rx_data == CMD_STOP);

  always_comb begin
    auth_next = auth_state;
    case (auth_state)
      AUTH_OFF:  if (consume_go) auth_next = AUTH_PWR1;
      AUTH_PWR1: if (consume_stop) auth_next = rider_off ? AUTH_OFF : AUTH_PWR2;
      // A fresh GO overrides a simultaneous dismount.
      AUTH_PWR2: begin
        if (consume_go) auth_next = AUTH_PWR1;
        else if (rider_off) auth_next = AUTH_OFF;
      end
      default:   auth_next = AUTH_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auth_state <= AUTH_OFF;
      pwr_up     <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      auth_state <= auth_next;
      pwr_up     <= (auth_state != AUTH_OFF);
      cmd_err    <= rx_rdy && !consume_go && !consume_stop;
    end
  end

  assign dbg_rx_busy    = (rx_state == RX_RECV);
  assign dbg_auth_state = auth_state;

endmodule

// File: tb/tb_ble_auth_rx.sv
// Bench for ble_auth_rx: directed UART frames, a command-level power model and a per-cycle compare.
// A shorter bit period keeps the run short; latency scales as 2 + BAUD/2 + 9*BAUD.
module tb_ble_auth_rx;
  localparam int         BAUD = 260;
  localparam int         LAT  = 2472;  // 2 + 130 + 9*260
  localparam logic [7:0] GO   = 8'h47;
  localparam logic [7:0] STOP = 8'h53;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy, pwr_up, frame_err, cmd_err, dbg_rx_busy;
  logic [1:0] dbg_auth_state;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rdy = 0, n_ferr = 0, n_cerr = 0;
  int r0, f0, c0;
  bit hit;

  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         ferr_t[$];
  logic       m_on = 1'b0, m_wait = 1'b0, exp_pwr = 1'b0, exp_cerr = 1'b0;
  logic [7:0] m_data = 8'h00;

  ble_auth_rx #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .pwr_up(pwr_up),
    .frame_err(frame_err), .cmd_err(cmd_err),
    .dbg_rx_busy(dbg_rx_busy), .dbg_auth_state(dbg_auth_state)
  );

  // Clock and cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Driver: one 8N1 frame, bits exactly BAUD cycles long; the expectation is queued at the start edge.
  task automatic uart_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    RX = 1'b0;
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_t.push_back(cyc);
    end else begin
      ferr_t.push_back(cyc);
    end
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1; RX = b[i];
      repeat (BAUD) @(posedge clk);
    end
    #1; RX = stop_bit;
    repeat (BAUD) @(posedge clk);
    #1; RX = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: command-level power model, checked every cycle out of reset
  always @(negedge clk) begin : cmp
    logic       got;
    logic [7:0] d;
    int         lat;
    if (rst) begin
      m_on = 1'b0; m_wait = 1'b0; exp_pwr = 1'b0; exp_cerr = 1'b0; m_data = 8'h00;
      exp_q.delete(); exp_t.delete(); ferr_t.delete();
    end else begin
      got = 1'b0;
      d = 8'h00;
      check(pwr_up == exp_pwr, "pwr_up", int'(pwr_up), int'(exp_pwr));
      check(cmd_err == exp_cerr, "cmd_err", int'(cmd_err), int'(exp_cerr));
      if (cmd_err) n_cerr++;
      if (rx_rdy) begin
        n_rdy++;
        if (exp_q.size() == 0) check(1'b0, "rx_rdy_unexpected", 1, 0);
        else begin
          d = exp_q.pop_front();
          lat = cyc - exp_t.pop_front();
          got = 1'b1;
          m_data = d;
          check(lat >= LAT - 2 && lat <= LAT + 2, "rx_rdy_latency", lat, LAT);
        end
      end else if (exp_q.size() != 0 && cyc - exp_t[0] > LAT + 2) begin
        check(1'b0, "rx_rdy_timeout", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
      end
      check(rx_data == m_data, "rx_data", int'(rx_data), int'(m_data));
      if (frame_err) begin
        n_ferr++;
        if (ferr_t.size() == 0) check(1'b0, "frame_err_unexpected", 1, 0);
        else begin
          lat = cyc - ferr_t.pop_front();
          check(lat >= LAT - 2 && lat <= LAT + 2, "frame_err_latency", lat, LAT);
        end
      end else if (ferr_t.size() != 0 && cyc - ferr_t[0] > LAT + 2) begin
        check(1'b0, "frame_err_timeout", 0, 1);
        void'(ferr_t.pop_front());
      end
      // pwr_up trails the decision by one cycle; cmd_err follows the consume cycle.
      exp_pwr  = m_on;
      exp_cerr = got && d != GO && d != STOP;
      if (got && d == GO) begin
        m_on = 1'b1; m_wait = 1'b0;
      end else if (got && d == STOP && m_on && !m_wait) begin
        if (rider_off) m_on = 1'b0;
        else m_wait = 1'b1;
      end else if (m_wait && rider_off) begin
        m_on = 1'b0; m_wait = 1'b0;
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst = 1'b1; RX = 1'b1; rider_off = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check(rx_data == 8'h00, "reset_rx_data", int'(rx_data), 0);
    check(rx_rdy == 1'b0, "reset_rx_rdy", int'(rx_rdy), 0);
    check(pwr_up == 1'b0, "reset_pwr_up", int'(pwr_up), 0);
    check(frame_err == 1'b0, "reset_frame_err", int'(frame_err), 0);
    check(cmd_err == 1'b0, "reset_cmd_err", int'(cmd_err), 0);
    check(dbg_rx_busy == 1'b0, "reset_rx_busy", int'(dbg_rx_busy), 0);
    check(dbg_auth_state == 2'd0, "reset_auth_state", int'(dbg_auth_state), 0);
    idle(20000);
    check(pwr_up == 1'b0, "idle_pwr_up", int'(pwr_up), 0);

    // Single GO
    r0 = n_rdy;
    uart_byte(GO, 1'b1);
    idle(20);
    check(n_rdy - r0 == 1, "go_rdy_count", n_rdy - r0, 1);
    check(rx_data == 8'h47, "go_rx_data", int'(rx_data), 'h47);
    check(pwr_up == 1'b1, "go_pwr_up", int'(pwr_up), 1);

    // STOP with rider on, then dismount
    uart_byte(STOP, 1'b1);
    idle(20);
    check(pwr_up == 1'b1, "stop_rider_on_pwr_up", int'(pwr_up), 1);
    @(posedge clk); #1; rider_off = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(pwr_up == 1'b0, "dismount_pwr_up", int'(pwr_up), 0);

    // STOP with rider already off
    uart_byte(GO, 1'b1);
    idle(20);
    check(pwr_up == 1'b1, "go_again_pwr_up", int'(pwr_up), 1);
    uart_byte(STOP, 1'b1);
    idle(20);
    check(pwr_up == 1'b0, "stop_rider_off_pwr_up", int'(pwr_up), 0);

    // In PWR2, GO arrives in the same cycle rider_off rises
    rider_off = 1'b0;
    uart_byte(GO, 1'b1);
    uart_byte(STOP, 1'b1);
    idle(20);
    check(pwr_up == 1'b1, "pwr2_pwr_up", int'(pwr_up), 1);
    hit = 1'b0;
    fork
      uart_byte(GO, 1'b1);
      begin
        for (int i = 0; i < 4000 && !hit; i++) begin
          @(posedge clk); #1;
          if (rx_rdy) begin
            rider_off = 1'b1;
            hit = 1'b1;
          end
        end
      end
    join
    check(hit, "consume_wait", int'(hit), 1);
    idle(20);
    check(pwr_up == 1'b1, "go_wins_pwr_up", int'(pwr_up), 1);
    @(posedge clk); #1; rider_off = 1'b0;

    // Unknown command, then a bad stop bit
    c0 = n_cerr;
    uart_byte(8'h41, 1'b1);
    idle(20);
    check(n_cerr - c0 == 1, "cmd_err_pulses", n_cerr - c0, 1);
    check(pwr_up == 1'b1, "cmd_err_pwr_up", int'(pwr_up), 1);
    check(rx_data == 8'h41, "cmd_err_rx_data", int'(rx_data), 'h41);
    f0 = n_ferr; r0 = n_rdy;
    uart_byte(8'h5A, 1'b0);
    idle(20);
    check(n_ferr - f0 == 1, "frame_err_pulses", n_ferr - f0, 1);
    check(n_rdy - r0 == 0, "frame_err_no_rdy", n_rdy - r0, 0);
    check(rx_data == 8'h41, "frame_err_rx_data_kept", int'(rx_data), 'h41);

    // Reset mid-byte, held until the aborted frame has passed
    r0 = n_rdy;
    fork
      uart_byte(GO, 1'b1);
      begin
        repeat (1000) @(posedge clk);
        #1; rst = 1'b1;
      end
    join
    @(posedge clk); #1; rst = 1'b0;
    idle(20);
    check(n_rdy - r0 == 0, "rst_mid_no_rdy", n_rdy - r0, 0);
    check(pwr_up == 1'b0, "rst_mid_pwr_up", int'(pwr_up), 0);
    check(rx_data == 8'h00, "rst_mid_rx_data", int'(rx_data), 0);

    // Back-to-back GO, STOP with rider on
    r0 = n_rdy;
    uart_byte(GO, 1'b1);
    uart_byte(STOP, 1'b1);
    idle(20);
    check(n_rdy - r0 == 2, "b2b_rdy_count", n_rdy - r0, 2);
    check(rx_data == 8'h53, "b2b_rx_data", int'(rx_data), 'h53);
    check(pwr_up == 1'b1, "b2b_pwr_up", int'(pwr_up), 1);

    check(exp_q.size() == 0, "pending_bytes", exp_q.size(), 0);
    check(ferr_t.size() == 0, "pending_frame_errs", ferr_t.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
